// File: rtl/alu_seq_ctrl_pkg.sv
// alu_seq_ctrl shared types: sequencer states, opcodes, writeback rule.
package alu_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_EXEC,
    SEQ_WAIT,
    SEQ_HOLD
  } seq_state_t;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_CMP  = 6'h02;
  localparam logic [5:0] OP_MUL  = 6'h03;
  localparam logic [5:0] OP_BTST = 6'h04;
  localparam logic [5:0] OP_RRC  = 6'h05;

  // CMP and BTST only produce flags
  function automatic logic no_wb(
    input logic [5:0] op
  );
    return (op == OP_CMP) || (op == OP_BTST);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request and result handshakes between decode,
// the ALU sequencer and writeback.
interface alu_seq_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_rd;
  logic        req_flag_we;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_rd;
  logic        res_we;

  modport master (
    output req_valid, req_opcode, req_a,
    output req_b, req_rd, req_flag_we,
    output res_ready,
    input  req_ready, res_valid, res_data,
    input  res_rd, res_we
  );

  modport slave (
    input  req_valid, req_opcode, req_a,
    input  req_b, req_rd, req_flag_we,
    input  res_ready,
    output req_ready, res_valid, res_data,
    output res_rd, res_we
  );

endinterface

// File: rtl/alu_flag_reg.sv
// Architectural C/V/Z/N flag register, written on
// a capture of a flag-updating operation.
module alu_flag_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic        we,
  input  logic [31:0] dout,
  input  logic        cout,
  input  logic        vout,
  output logic        c,
  output logic        v,
  output logic        z,
  output logic        n
);

  always_ff @(posedge clk) begin
    if (rst) begin
      c <= 1'b0;
      v <= 1'b0;
      z <= 1'b0;
      n <= 1'b0;
    end else if (cap && we) begin
      c <= cout;
      v <= vout;
      z <= (dout == 32'd0);
      n <= dout[31];
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Issues one op at a time to the ALU, holds operands
// across multi-cycle paths and presents the result.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int MCP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  alu_seq_ctrl_if.slave bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_opcode,
  output logic        alu_cin,
  output logic        alu_vin,
  input  logic [31:0] alu_dout,
  input  logic        alu_cout,
  input  logic        alu_vout,
  input  logic        alu_mcp,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flag_z,
  output logic        flag_n,
  output logic        busy
);

  seq_state_t  state;
  seq_state_t  nxt;
  logic [3:0]  cnt;
  logic [3:0]  rd_q;
  logic        fwe_q;
  logic        hs;
  logic        cap;

  always_comb begin
    bus.req_ready = 1'b0;
    unique case (state)
      SEQ_IDLE: bus.req_ready = !flush;
      SEQ_HOLD: bus.req_ready = bus.res_ready && !flush;
      default:  bus.req_ready = 1'b0;
    endcase
  end

  assign hs = bus.req_valid && bus.req_ready;

  // flush suppresses a capture due in the same cycle
  assign cap = !flush &&
    (((state == SEQ_EXEC) && !alu_mcp) ||
     ((state == SEQ_WAIT) && (cnt == 4'd1)));

  always_comb begin
    nxt = state;
    unique case (state)
      SEQ_IDLE: if (hs) nxt = SEQ_EXEC;
      SEQ_EXEC: nxt = alu_mcp ? SEQ_WAIT : SEQ_HOLD;
      SEQ_WAIT: if (cnt == 4'd1) nxt = SEQ_HOLD;
      SEQ_HOLD: if (bus.res_ready)
                  nxt = hs ? SEQ_EXEC : SEQ_IDLE;
      default:  nxt = SEQ_IDLE;
    endcase
    if (flush) nxt = SEQ_IDLE;
  end

  assign bus.res_valid = (state == SEQ_HOLD);
  assign busy          = (state != SEQ_IDLE);
  assign alu_cin       = flag_c;
  assign alu_vin       = flag_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEQ_IDLE;
      cnt          <= 4'd0;
      alu_a        <= 32'd0;
      alu_b        <= 32'd0;
      alu_opcode   <= 6'd0;
      rd_q         <= 4'd0;
      fwe_q        <= 1'b0;
      bus.res_data <= 32'd0;
      bus.res_rd   <= 4'd0;
      bus.res_we   <= 1'b0;
    end else begin
      state <= nxt;
      if (hs) begin
        alu_a      <= bus.req_a;
        alu_b      <= bus.req_b;
        alu_opcode <= bus.req_opcode;
        rd_q       <= bus.req_rd;
        fwe_q      <= bus.req_flag_we;
      end
      if (flush)
        cnt <= 4'd0;
      else if ((state == SEQ_EXEC) && alu_mcp)
        cnt <= 4'(MCP_CYCLES);
      else if (state == SEQ_WAIT)
        cnt <= cnt - 4'd1;
      if (cap) begin
        bus.res_data <= alu_dout;
        bus.res_rd   <= rd_q;
        bus.res_we   <= !no_wb(alu_opcode);
      end
    end
  end

  alu_flag_reg u_flags (
    .clk  (clk),
    .rst  (rst),
    .cap  (cap),
    .we   (fwe_q),
    .dout (alu_dout),
    .cout (alu_cout),
    .vout (alu_vout),
    .c    (flag_c),
    .v    (flag_v),
    .z    (flag_z),
    .n    (flag_n)
  );

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer between instruction decode and the `alu` datapath. It accepts one ALU operation at a time over a valid/ready handshake and registers the operands into the ALU. It holds those operands for extra cycles whenever the ALU flags a multi-cycle path (`mcp_out`, e.g. MUL32), then captures the result and C/V/Z/N flags and presents the result to writeback over a second valid/ready handshake.

## Interface
- `MCP_CYCLES`, default 2: extra cycles operands are held after the ALU asserts `mcp_out`; legal range 1–15.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous abort of the in-flight operation.
- `req_valid` in 1: operation offered.
- `req_ready` out 1: operation accepted when both `req_valid` and `req_ready` are high.
- `req_opcode` in 6: opcode, encodings from `cpu_2432.vh`.
- `req_a`, `req_b` in 32 each: operands.
- `req_rd` in 4: destination register tag.
- `req_flag_we` in 1: the operation updates the flag register.
- `alu_a`, `alu_b` out 32 each: registered operands to the ALU.
- `alu_opcode` out 6: registered opcode.
- `alu_cin`, `alu_vin` out 1 each: current `flag_c`, `flag_v`.
- `alu_dout` in 32, `alu_cout` in 1, `alu_vout` in 1: ALU outputs.
- `alu_mcp` in 1: ALU multi-cycle flag.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out 32: captured result.
- `res_rd` out 4: captured destination tag.
- `res_we` out 1: register writeback required.
- `flag_c`, `flag_v`, `flag_z`, `flag_n` out 1 each: architectural flags.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - EXEC: first ALU cycle.
  - WAIT: multi-cycle hold.
  - HOLD: result presented.
- IDLE → EXEC on handshake. The cycle the handshake completes, latch opcode, a, b, rd and flag_we into the `alu_*` registers.
- EXEC:
  - If `alu_mcp`=0, capture the result at the end of EXEC and go to HOLD.
  - If `alu_mcp`=1, load the hold counter with `MCP_CYCLES` and go to WAIT.
- WAIT: decrement the counter each cycle. Capture when the counter reaches 1, then go to HOLD. The `alu_*` registers stay stable throughout.
- Capture:
  - `res_data`←`alu_dout`; `res_rd`←latched rd.
  - `res_we`←0 for CMP and BTST, 1 otherwise.
  - If flag_we: `flag_c`←`alu_cout`, `flag_v`←`alu_vout`, `flag_z`←(`alu_dout`==0), `flag_n`←`alu_dout[31]`.
- HOLD:
  - `res_valid`=1.
  - `req_ready`=`res_ready`, giving back-to-back issue.
  - If `res_ready` and `req_valid` are both high, go to EXEC with the new operation latched.
  - If only `res_ready` is high, go to IDLE.
  - `res_data`, `res_rd` and `res_we` are stable while `res_valid`=1 and `res_ready`=0.
- `alu_cin`/`alu_vin` always reflect the flag register. Flags written at one capture are therefore visible to the next operation's EXEC.
- `flush`: next state is IDLE and any pending result is dropped. A capture due in the same cycle does not occur, so flags are unchanged. `flush` overrides a simultaneous request handshake; `req_ready`=0 while `flush`=1.
- `rst`: state IDLE. All outputs and registers are 0, including flags, `alu_*` registers, `res_*`, `busy` and the counter. `rst` has priority over `flush` and everything else. Reset mid-WAIT or mid-HOLD discards the operation.

## Timing
- Single-cycle operation: handshake in cycle 0, EXEC in cycle 1, `res_valid` from cycle 2.
- Multi-cycle operation: `res_valid` from cycle 2+`MCP_CYCLES`.
- Throughput with `res_ready` tied high: one single-cycle operation per 2 cycles. The HOLD→EXEC overlap hides IDLE.
- No combinational path from `req_*` to `alu_*`. `res_*` and the flags are registered.
- `req_ready` depends combinationally on `res_ready` and `flush` only.
- `alu_mcp` is sampled only in EXEC; it is ignored in WAIT.

## Structure
- Opcode mnemonics (ADD, SUB, CMP, MUL, BTST, …) come from `cpu_2432.vh`.
- Add the state encodings `SEQ_IDLE`, `SEQ_EXEC`, `SEQ_WAIT`, `SEQ_HOLD` and the CMP/BTST no-writeback opcode list to that header.
- One natural sub-module, `alu_flag_reg`: the flag register with capture enable, flag_we qualification and Z/N derivation.
- The `alu` is instantiated alongside the block, not inside it.

## Test plan
- Single-cycle issue:
  - Stimulus: ADD a=0x7FFFFFFF, b=1, flag_we=1, `alu_mcp`=0.
  - Required: `res_valid` at cycle 2; `res_data`=0x80000000; V=1, N=1, Z=0, C=0; `res_we`=1.
- Multi-cycle issue:
  - Stimulus: MUL with `alu_mcp`=1, `MCP_CYCLES`=2.
  - Required: `alu_a`/`alu_b` stable for cycles 1–3; `res_valid` at cycle 4; `busy` high in cycles 1–4.
- CMP with backpressure:
  - Stimulus: CMP a=5, b=5, `res_ready` held 0 for 3 cycles.
  - Required: Z=1, `res_we`=0; `res_data`=0 stable throughout; `req_ready`=0 until `res_ready` rises.
- Back-to-back and carry chaining:
  - Stimulus: ADD 0xFFFFFFFF+1 (C=1), then a rotate-through-carry issued in HOLD.
  - Required: the second operation sees `alu_cin`=1 in its EXEC cycle; there is no IDLE cycle between the two operations.
- Flush mid-operation:
  - Stimulus: `flush` asserted in the final WAIT cycle of a MUL.
  - Required: no `res_valid`; flags unchanged; IDLE and `req_ready`=1 on the next cycle.
- Reset mid-HOLD:
  - Stimulus: `rst` asserted with a result pending.
  - Required: next cycle `res_valid`=0, all flags 0, `busy`=0, `req_ready`=1 once `rst` deasserts.
